// File: rtl/lstm_weight_loader.sv
// LSTM gate weight/bias loader: deals a serial weight stream round-robin into
// per-gate FIFOs, pops all lanes together as sign-extended fixed-point words,
// and holds a loadable per-gate bias RAM with parallel read.
module lstm_weight_loader #(
  parameter int GATES      = 4,
  parameter int W_IN       = 8,
  parameter int ACC_W      = 24,
  parameter int FRAC_SHIFT = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int HIDDEN     = 512,
  parameter int BIAS_W     = 16,
  parameter int FRAME_LEN  = 1024
) (
  input  logic                         user_clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         w_valid,
  input  logic [W_IN-1:0]              w_data,
  output logic                         w_ready,
  input  logic                         bias_wr_valid,
  input  logic [BIAS_W-1:0]            bias_wr_data,
  input  logic [$clog2(HIDDEN)-1:0]    bias_rd_addr,
  output logic [GATES*BIAS_W-1:0]      bias_rd_data,
  input  logic                         rd_en,
  output logic                         lanes_ready,
  output logic [GATES*ACC_W-1:0]       weight_out,
  output logic                         weight_out_valid,
  output logic                         frame_done,
  output logic                         bias_done,
  output logic                         err_underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GATES > 1) ? $clog2(GATES) : 1;
  localparam int HW = $clog2(HIDDEN);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [GW-1:0] G_LAST   = GW'(GATES - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HIDDEN - 1);
  localparam logic [FW-1:0] F_LAST   = FW'(FRAME_LEN - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {LOAD, DONE} bias_state_t;

  // Sign-extend a stored weight to the accumulator width and align its binary point.
  function automatic logic signed [ACC_W-1:0] align_w(input logic signed [W_IN-1:0] w);
    logic signed [ACC_W-1:0] ext;
    ext = {{(ACC_W-W_IN){w[W_IN-1]}}, w};
    return ext <<< FRAC_SHIFT;
  endfunction

  logic signed [W_IN-1:0]   fifo_mem [GATES][FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr   [GATES];
  logic [AW:0]              cnt      [GATES];
  logic [AW-1:0]            rd_ptr;
  logic [GW-1:0]            gptr;
  logic [FW-1:0]            wcnt;
  logic [GATES-1:0]         full, empty, wr_lane;
  logic                     accept, pop, frame_last;
  logic signed [ACC_W-1:0]  weight_p1 [GATES];
  logic                     vld_p1;
  logic                     err_q;

  logic [BIAS_W-1:0]        bias_mem [GATES][HIDDEN];
  logic [BIAS_W-1:0]        bias_p1  [GATES];
  bias_state_t              bstate, bstate_nxt;
  logic [GW-1:0]            bbank;
  logic [HW-1:0]            baddr;
  logic                     bias_we;

  // Lane status, handshakes and per-lane write strobes. Full uses the pre-pop count.
  always_comb begin
    full    = '0;
    empty   = '0;
    wr_lane = '0;
    for (int g = 0; g < GATES; g++) begin
      full[g]  = (cnt[g] == CNT_FULL);
      empty[g] = (cnt[g] == '0);
    end
    w_ready     = !full[gptr];
    lanes_ready = &(~empty);
    accept      = w_valid && w_ready && !clear && !rst;
    pop         = rd_en && lanes_ready && !clear && !rst;
    frame_last  = accept && (wcnt == F_LAST);
    for (int g = 0; g < GATES; g++) begin
      wr_lane[g] = accept && (gptr == GW'(g));
    end
  end

  // Stage p0: lane pointers, occupancy, frame counter and underrun flag.
  always_ff @(posedge user_clk) begin
    if (rst || clear) begin
      gptr   <= '0;
      wcnt   <= '0;
      rd_ptr <= '0;
      err_q  <= 1'b0;
      vld_p1 <= 1'b0;
      for (int g = 0; g < GATES; g++) begin
        wr_ptr[g] <= '0;
        cnt[g]    <= '0;
      end
    end else begin
      vld_p1 <= pop;
      if (rd_en && !lanes_ready) err_q <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept) begin
        if (frame_last) begin
          wcnt <= '0;
          gptr <= '0;
        end else begin
          wcnt <= wcnt + 1'b1;
          gptr <= (gptr == G_LAST) ? '0 : gptr + 1'b1;
        end
      end
      for (int g = 0; g < GATES; g++) begin
        if (wr_lane[g]) wr_ptr[g] <= wr_ptr[g] + 1'b1;
        if (wr_lane[g] && !pop)      cnt[g] <= cnt[g] + 1'b1;
        else if (!wr_lane[g] && pop) cnt[g] <= cnt[g] - 1'b1;
      end
    end
  end

  // FIFO storage writes.
  always_ff @(posedge user_clk) begin
    for (int g = 0; g < GATES; g++) begin
      if (wr_lane[g]) fifo_mem[g][wr_ptr[g]] <= w_data;
    end
  end

  // Stage p1: popped words, aligned; held while no pop occurs.
  always_ff @(posedge user_clk) begin
    for (int g = 0; g < GATES; g++) begin
      if (rst || clear)  weight_p1[g] <= '0;
      else if (pop)      weight_p1[g] <= align_w(fifo_mem[g][rd_ptr]);
    end
  end

  // Bias load FSM next state and write strobe.
  always_comb begin
    bstate_nxt = bstate;
    bias_we    = 1'b0;
    if (bstate == LOAD && bias_wr_valid && !clear && !rst) begin
      bias_we = 1'b1;
      if (bbank == G_LAST && baddr == H_LAST) bstate_nxt = DONE;
    end
  end

  // Bias load FSM state and bank/address counters.
  always_ff @(posedge user_clk) begin
    if (rst || clear) begin
      bstate <= LOAD;
      bbank  <= '0;
      baddr  <= '0;
    end else begin
      bstate <= bstate_nxt;
      if (bias_we) begin
        if (bbank == G_LAST) begin
          bbank <= '0;
          baddr <= baddr + 1'b1;
        end else begin
          bbank <= bbank + 1'b1;
        end
      end
    end
  end

  // Bias RAM writes.
  always_ff @(posedge user_clk) begin
    for (int g = 0; g < GATES; g++) begin
      if (bias_we && bbank == GW'(g)) bias_mem[g][baddr] <= bias_wr_data;
    end
  end

  // Stage p1: parallel bias read; a same-address write returns the old word.
  always_ff @(posedge user_clk) begin
    for (int g = 0; g < GATES; g++) begin
      if (rst || clear) bias_p1[g] <= '0;
      else              bias_p1[g] <= bias_mem[g][bias_rd_addr];
    end
  end

  // Output packing.
  always_comb begin
    weight_out   = '0;
    bias_rd_data = '0;
    for (int g = 0; g < GATES; g++) begin
      weight_out[g*ACC_W +: ACC_W]    = weight_p1[g];
      bias_rd_data[g*BIAS_W +: BIAS_W] = bias_p1[g];
    end
  end

  assign weight_out_valid = vld_p1;
  assign frame_done       = frame_last;
  assign bias_done        = (bstate == DONE);
  assign err_underrun     = err_q;

endmodule

// File: tb/tb_lstm_weight_loader.sv
// Directed bench for lstm_weight_loader at default parameters.
module tb_lstm_weight_loader;

  logic        user_clk = 1'b0;
  logic        rst = 1'b1, clear = 1'b0;
  logic        w_valid = 1'b0;
  logic [7:0]  w_data = '0;
  logic        w_ready;
  logic        bias_wr_valid = 1'b0;
  logic [15:0] bias_wr_data = '0;
  logic [8:0]  bias_rd_addr = '0;
  logic [63:0] bias_rd_data;
  logic        rd_en = 1'b0;
  logic        lanes_ready;
  logic [95:0] weight_out;
  logic        weight_out_valid, frame_done, bias_done, err_underrun;

  int n_cmp = 0;
  int n_err = 0;
  int stalls;

  lstm_weight_loader dut (
    .user_clk(user_clk), .rst(rst), .clear(clear),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .bias_wr_valid(bias_wr_valid), .bias_wr_data(bias_wr_data),
    .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
    .rd_en(rd_en), .lanes_ready(lanes_ready),
    .weight_out(weight_out), .weight_out_valid(weight_out_valid),
    .frame_done(frame_done), .bias_done(bias_done), .err_underrun(err_underrun)
  );

  always #5 user_clk = ~user_clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  function automatic logic [95:0] pack_w(input logic [23:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [63:0] pack_b(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic put_word(input logic [7:0] d);
    w_valid = 1'b1;
    w_data  = d;
    step();
    w_valid = 1'b0;
  endtask

  task automatic pop_once();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check_val("rst_w_ready", w_ready, 1);
    check_val("rst_lanes_ready", lanes_ready, 0);
    check_val("rst_weight_out", weight_out, 0);
    check_val("rst_valid", weight_out_valid, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_bias_done", bias_done, 0);
    check_val("rst_err", err_underrun, 0);
    check_val("rst_bias_rd", bias_rd_data, 0);
    rst = 1'b0;

    // Eight words dealt round-robin, then one all-lane pop
    for (int i = 1; i <= 8; i++) put_word(8'(i));
    check_val("fill_lanes_ready", lanes_ready, 1);
    pop_once();
    check_val("pop1_data", weight_out, pack_w(24'h000200, 24'h000400, 24'h000600, 24'h000800));
    check_val("pop1_valid", weight_out_valid, 1);
    check_val("pop1_second_set", lanes_ready, 1);
    step();
    check_val("pop1_valid_drop", weight_out_valid, 0);
    check_val("pop1_hold", weight_out, pack_w(24'h000200, 24'h000400, 24'h000600, 24'h000800));
    pop_once();
    check_val("pop2_data", weight_out, pack_w(24'h000A00, 24'h000C00, 24'h000E00, 24'h001000));
    check_val("pop2_empty", lanes_ready, 0);

    // Sign extension boundaries
    put_word(8'h80); put_word(8'h7F); put_word(8'h01); put_word(8'hFF);
    pop_once();
    check_val("sign_data", weight_out, pack_w(24'hFF0000, 24'h00FE00, 24'h000200, 24'hFFFE00));
    check_val("sign_no_err", err_underrun, 0);

    // Fill every lane to depth, then a retried write coincident with a pop
    for (int i = 0; i < 64; i++) put_word(8'(i));
    w_valid = 1'b1;
    w_data  = 8'h55;
    rd_en   = 1'b1;
    #1;
    check_val("full_w_ready", w_ready, 0);
    step();
    rd_en = 1'b0;
    check_val("full_pop_data", weight_out, pack_w(24'h000000, 24'h000200, 24'h000400, 24'h000600));
    check_val("after_pop_w_ready", w_ready, 1);
    step();
    w_valid = 1'b0;
    for (int i = 0; i < 15; i++) pop_once();
    check_val("drain_last", weight_out, pack_w(24'h007800, 24'h007A00, 24'h007C00, 24'h007E00));
    check_val("drain_lanes_ready", lanes_ready, 0);

    // Underrun with lane 3 empty
    put_word(8'h21); put_word(8'h22);
    pop_once();
    check_val("under_valid", weight_out_valid, 0);
    check_val("under_err", err_underrun, 1);
    check_val("under_hold", weight_out, pack_w(24'h007800, 24'h007A00, 24'h007C00, 24'h007E00));
    step();
    check_val("under_sticky", err_underrun, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_val("clr_err", err_underrun, 0);
    check_val("clr_lanes_ready", lanes_ready, 0);
    check_val("clr_w_ready", w_ready, 1);
    check_val("clr_weight_out", weight_out, 0);
    check_val("clr_valid", weight_out_valid, 0);

    // One full frame streamed with concurrent pops
    stalls = 0;
    for (int i = 0; i < 1024; i++) begin
      w_valid = 1'b1;
      w_data  = i[7:0];
      rd_en   = lanes_ready;
      #1;
      if (!w_ready) stalls++;
      check_val($sformatf("frame_done_%0d", i), frame_done, (i == 1023));
      step();
    end
    w_valid = 1'b0;
    rd_en   = 1'b0;
    check_val("frame_stalls", stalls, 0);
    for (int k = 0; k < 40 && lanes_ready; k++) begin
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    check_val("frame_drained", lanes_ready, 0);
    check_val("frame_no_err", err_underrun, 0);
    put_word(8'h11); put_word(8'h22); put_word(8'h33); put_word(8'h44);
    pop_once();
    check_val("next_frame_lane0", weight_out, pack_w(24'h002200, 24'h004400, 24'h006600, 24'h008800));

    // Bias load of index values
    for (int i = 0; i < 2048; i++) begin
      bias_wr_valid = 1'b1;
      bias_wr_data  = 16'(i);
      if (i == 2047) begin
        #1;
        check_val("bias_not_done_yet", bias_done, 0);
      end
      step();
    end
    bias_wr_valid = 1'b0;
    check_val("bias_done", bias_done, 1);
    bias_rd_addr = 9'd5;
    step();
    check_val("bias_addr5", bias_rd_data, pack_b(16'd20, 16'd21, 16'd22, 16'd23));
    bias_wr_valid = 1'b1;
    bias_wr_data  = 16'hBEEF;
    bias_rd_addr  = 9'd0;
    step();
    bias_wr_valid = 1'b0;
    step();
    check_val("bias_extra_ignored", bias_rd_data, pack_b(16'd0, 16'd1, 16'd2, 16'd3));

    // Clear keeps RAM; reload with read-during-write returning old data
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_val("clr_bias_done", bias_done, 0);
    check_val("clr_bias_rd", bias_rd_data, 0);
    for (int i = 0; i < 4; i++) begin
      bias_wr_valid = 1'b1;
      bias_wr_data  = 16'h1000 + 16'(i);
      step();
      if (i == 0) check_val("bias_rdw_old", bias_rd_data, pack_b(16'd0, 16'd1, 16'd2, 16'd3));
    end
    bias_wr_valid = 1'b0;
    step();
    check_val("bias_reload", bias_rd_data, pack_b(16'h1000, 16'h1001, 16'h1002, 16'h1003));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
